uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_byte_timer.sv | 45 ++++
 rtl/uart_frame_parser.sv | 175 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// +----------------------------------------------------------------------------+
// | Module     : uart_frame_pkg                                                |
// | Description: Shared parser state encoding and default framing bytes.       |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_HDR1 = 3'd1,
    GET_CTRL = 3'd2,
    GET_PAY  = 3'd3,
    GET_CHK  = 3'd4,
    GET_TAIL = 3'd5
  } state_t;

  localparam logic [7:0] DEF_HDR0 = 8'hAB;
  localparam logic [7:0] DEF_HDR1 = 8'hCD;
  localparam logic [7:0] DEF_TAIL = 8'hEF;

endpackage

`default_nettype wire

// File: rtl/uart_byte_timer.sv
// +----------------------------------------------------------------------------+
// | Module     : uart_byte_timer                                               |
// | Description: Inter-byte watchdog; expires after TIMEOUT_CYC idle cycles.   |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_byte_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic sclk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // A byte arriving on the expiry cycle wins, so clr masks expiry.
  assign expired = run && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!run || clr) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_frame_parser.sv
// +----------------------------------------------------------------------------+
// | Module     : uart_frame_parser                                             |
// | Description: Byte-stream frame parser HDR0 HDR1 CTRL PAYLOAD [CHK] TAIL.   |
// |              Define UART_FRAME_CHKSUM_EN to require the CHK byte.          |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HDR0          = DEF_HDR0,
  parameter logic [7:0] HDR1          = DEF_HDR1,
  parameter logic [7:0] TAIL          = DEF_TAIL,
  parameter int         PAYLOAD_BYTES = 4,
  parameter int         TIMEOUT_CYC   = 50000
) (
  input  logic                         sclk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_done,
  output logic [7:0]                   ctrl,
  output logic [8*PAYLOAD_BYTES-1:0]   payload,
  output logic                         frame_valid,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int CNT_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAYLOAD_BYTES - 1);

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [7:0]                   ctrl_sh_q, ctrl_sh_d;
  logic [8*PAYLOAD_BYTES-1:0]   pay_sh_q, pay_sh_d;
  logic [7:0]                   ctrl_q, ctrl_d;
  logic [8*PAYLOAD_BYTES-1:0]   payload_q, payload_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         frame_err_q, frame_err_d;
  logic                         busy_q, busy_d;
  logic                         timer_run;
  logic                         timer_expired;
`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0]                   sum_q, sum_d;
`endif

  assign timer_run = (state_q != IDLE);

  uart_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .sclk    (sclk),
    .rst     (rst),
    .clr     (rx_done),
    .run     (timer_run),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ctrl_sh_d     = ctrl_sh_q;
    pay_sh_d      = pay_sh_q;
    ctrl_d        = ctrl_q;
    payload_d     = payload_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
    sum_d         = sum_q;
`endif
    if (rx_done) begin
      case (state_q)
        IDLE: begin
          if (rx_data == HDR0) state_d = GET_HDR1;
        end
        GET_HDR1: begin
          if (rx_data == HDR1)      state_d = GET_CTRL;
          else if (rx_data == HDR0) state_d = GET_HDR1;
          else                      state_d = IDLE;
        end
        GET_CTRL: begin
          ctrl_sh_d = rx_data;
          cnt_d     = '0;
`ifdef UART_FRAME_CHKSUM_EN
          sum_d     = rx_data;
`endif
          state_d   = GET_PAY;
        end
        GET_PAY: begin
          for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            if (cnt_q == CNT_W'(k)) pay_sh_d[8*k +: 8] = rx_data;
          end
`ifdef UART_FRAME_CHKSUM_EN
          sum_d = sum_q + rx_data;
`endif
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
`ifdef UART_FRAME_CHKSUM_EN
            state_d = GET_CHK;
`else
            state_d = GET_TAIL;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_FRAME_CHKSUM_EN
        GET_CHK: begin
          if (rx_data == sum_q) begin
            state_d = GET_TAIL;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
`endif
        GET_TAIL: begin
          if (rx_data == TAIL) begin
            ctrl_d        = ctrl_sh_q;
            payload_d     = pay_sh_q;
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timer_expired) begin
      frame_err_d = 1'b1;
      state_d     = IDLE;
      cnt_d       = '0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ctrl_sh_q     <= '0;
      pay_sh_q      <= '0;
      ctrl_q        <= '0;
      payload_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_FRAME_CHKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ctrl_sh_q     <= ctrl_sh_d;
      pay_sh_q      <= pay_sh_d;
      ctrl_q        <= ctrl_d;
      payload_q     <= payload_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
`ifdef UART_FRAME_CHKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign ctrl        = ctrl_q;
  assign payload     = payload_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
// +----------------------------------------------------------------------------+
// | Module     : tb_uart_frame_parser                                          |
// | Description: Directed scoreboard bench for uart_frame_parser.              |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_frame_parser;

  localparam int TOUT = 40;

  logic        sclk = 1'b0;
  logic        rst  = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [7:0]  ctrl;
  logic [31:0] payload;
  logic        frame_valid, frame_err, busy;

  typedef struct {
    bit          err;
    logic [7:0]  c;
    logic [31:0] p;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_ctrl = 8'h00;
  logic [31:0] exp_pay  = 32'h0;

  uart_frame_parser #(
    .PAYLOAD_BYTES (4),
    .TIMEOUT_CYC   (TOUT)
  ) dut (
    .sclk        (sclk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .ctrl        (ctrl),
    .payload     (payload),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sclk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge sclk);
    rx_done = 1'b0;
  endtask

  // Sends HDR0 HDR1 c p[7:0]..p[31:24] [sum+delta] tail.
  task automatic send_frame(input logic [7:0] c, input logic [31:0] p,
                            input logic [7:0] tail, input logic [7:0] chk_delta);
    logic [7:0] s;
    s = c + p[7:0] + p[15:8] + p[23:16] + p[31:24] + chk_delta;
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(c);
    for (int i = 0; i < 4; i++) send_byte(p[8*i +: 8]);
`ifdef UART_FRAME_CHKSUM_EN
    send_byte(s);
`endif
    send_byte(tail);
  endtask

  task automatic push_valid(input logic [7:0] c, input logic [31:0] p);
    ev_t e;
    exp_ctrl = c;
    exp_pay  = p;
    e.err = 1'b0; e.c = c; e.p = p;
    sb.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.err = 1'b1; e.c = exp_ctrl; e.p = exp_pay;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge sclk);
    chk(tag, 40'(sb.size()), 40'd0);
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expectation.
  always @(negedge sclk) begin
    if (rst && (frame_valid || frame_err)) begin
      chk("valid_and_err_exclusive", 40'(frame_valid && frame_err), 40'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {38'd0, frame_valid, frame_err}, 40'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("pulse_kind", {39'd0, frame_err}, {39'd0, e.err});
        chk("ctrl", {32'd0, ctrl}, {32'd0, e.c});
        chk("payload", {8'd0, payload}, {8'd0, e.p});
      end
    end
  end

  initial begin
    int n;
    #2;
    chk("reset_ctrl", {32'd0, ctrl}, 40'd0);
    chk("reset_payload", {8'd0, payload}, 40'd0);
    chk("reset_pulses", {38'd0, frame_valid, frame_err}, 40'd0);
    chk("reset_busy", {39'd0, busy}, 40'd0);
    repeat (3) @(negedge sclk);
    rst = 1'b1;
    repeat (2) @(negedge sclk);

    // Basic good frame
    push_valid(8'h05, 32'h44332211);
    send_frame(8'h05, 32'h44332211, 8'hEF, 8'h00);
    drain("drain_basic");
    chk("busy_after_frame", {39'd0, busy}, 40'd0);

    // Resync on repeated HDR0
    send_byte(8'hAB);
    push_valid(8'h01, 32'h02000000);
    send_frame(8'h01, 32'h02000000, 8'hEF, 8'h00);
    drain("drain_resync");

    // Bad tail keeps previous frame
    push_err();
    send_frame(8'h07, 32'h04030201, 8'hEE, 8'h00);
    drain("drain_badtail");
    chk("ctrl_kept", {32'd0, ctrl}, 40'h01);
    chk("payload_kept", {8'd0, payload}, 40'h02000000);

    // Noise in IDLE and a broken header produce no pulse
    send_byte(8'h12);
    send_byte(8'hCD);
    send_byte(8'hAB);
    send_byte(8'h34);
    drain("drain_noise");
    chk("busy_after_noise", {39'd0, busy}, 40'd0);

    // Inter-byte timeout
    push_err();
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h07);
    chk("busy_in_frame", {39'd0, busy}, 40'd1);
    n = 0;
    while (n < TOUT + 10) begin
      @(negedge sclk);
      n++;
      if (frame_err) break;
    end
    chk("timeout_cycles", 40'(n), 40'(TOUT));
    chk("busy_after_timeout", {39'd0, busy}, 40'd0);
    push_valid(8'h5A, 32'hDEADBEEF);
    send_frame(8'h5A, 32'hDEADBEEF, 8'hEF, 8'h00);
    drain("drain_timeout");

    // Byte landing on the expiry cycle wins over the timeout
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h3C);
    repeat (TOUT - 2) @(negedge sclk);
    send_byte(8'hA1);
    chk("busy_after_late_byte", {39'd0, busy}, 40'd1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
`ifdef UART_FRAME_CHKSUM_EN
    send_byte(8'h3C + 8'hA1 + 8'hB2 + 8'hC3 + 8'hD4);
`endif
    push_valid(8'h3C, 32'hD4C3B2A1);
    send_byte(8'hEF);
    drain("drain_priority");

`ifdef UART_FRAME_CHKSUM_EN
    push_valid(8'h01, 32'h01010101);
    send_frame(8'h01, 32'h01010101, 8'hEF, 8'h00);
    drain("drain_chk_good");
    push_err();
    send_frame(8'h01, 32'h01010101, 8'hEF, 8'h01);
    drain("drain_chk_bad");
`endif

    // Reset mid-frame
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h05);
    send_byte(8'h11);
    #3 rst = 1'b0;
    #1;
    chk("midrst_ctrl", {32'd0, ctrl}, 40'd0);
    chk("midrst_payload", {8'd0, payload}, 40'd0);
    chk("midrst_pulses", {38'd0, frame_valid, frame_err}, 40'd0);
    chk("midrst_busy", {39'd0, busy}, 40'd0);
    exp_ctrl = 8'h00;
    exp_pay  = 32'h0;
    repeat (2) @(negedge sclk);
    rst = 1'b1;
    repeat (TOUT + 5) @(negedge sclk);
    chk("midrst_quiet", 40'(sb.size()), 40'd0);
    push_valid(8'h05, 32'h44332211);
    send_frame(8'h05, 32'h44332211, 8'hEF, 8'h00);
    drain("drain_after_rst");
    chk("final_ctrl", {32'd0, ctrl}, 40'h05);
    chk("final_payload", {8'd0, payload}, 40'h44332211);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
